// File: rtl/merge_n_sync_pkg.sv
// Shared types and elaboration limits for the N-input controlled merge.
package merge_pkg;

    typedef enum logic {S_SEL, S_DATA} merge_state_t;

    localparam int MAX_NUM_IN = 16;
    localparam int MAX_DEPTH  = 64;

endpackage

// File: rtl/merge_n_sync_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth and an explicit
// occupancy counter. Head output reads as zero while empty.
module sync_fifo
    import merge_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("sync_fifo: DEPTH out of range");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;

    // Pointers wrap by explicit compare so any depth works.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers; storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count     = count_q;
    assign full      = (count_q == CNTW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty))
        else $error("sync_fifo: pop while empty");
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full))
        else $error("sync_fifo: push while full");
`endif

endmodule

// File: rtl/merge_n_sync.sv
// N-input controlled merge: a selector token picks which input channel
// supplies the next packet; packets queue in an output FIFO.
// Optional MERGE_SEL_CHECK_EN adds a sticky sel_err output for
// out-of-range selectors.
module merge_n_sync
    import merge_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int NUM_IN = 4,
    parameter  int DEPTH  = 4,
    localparam int SELW   = $clog2(NUM_IN),
    localparam int CNTW   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SELW-1:0]         sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNTW-1:0]         count
`ifdef MERGE_SEL_CHECK_EN
    ,
    output logic                    sel_err
`endif
);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
        $error("merge_n_sync: NUM_IN out of range");
    end

    merge_state_t     state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             sel_oor;
    logic             chan_vld;
    logic [WIDTH-1:0] chan_data;
    logic             push, pop;
    logic             fifo_full, fifo_empty;

    // Widened compare so a power-of-two NUM_IN is not a constant comparison.
    assign sel_oor = ({1'b0, sel} >= (SELW + 1)'(NUM_IN));

    // Input mux: valid and data of the channel named by the latched selector.
    always_comb begin
        chan_vld  = 1'b0;
        chan_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_q == SELW'(i)) begin
                chan_vld  = in_valid[i];
                chan_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM next-state and handshake outputs; full FIFO holds off the push.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_ready = 1'b0;
        in_ready  = '0;
        push      = 1'b0;
        case (state_q)
            S_SEL: begin
                sel_ready = 1'b1;
                if (sel_valid && !sel_oor) begin
                    sel_d   = sel;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                for (int i = 0; i < NUM_IN; i++)
                    in_ready[i] = (sel_q == SELW'(i)) && !fifo_full;
                push = chan_vld && !fifo_full;
                if (push) state_d = S_SEL;
            end
            default: state_d = S_SEL;
        endcase
    end

    // State and selector registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SEL;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef MERGE_SEL_CHECK_EN
    logic sel_err_q;

    // Sticky flag for a consumed out-of-range selector.
    always_ff @(posedge clk) begin
        if (reset)
            sel_err_q <= 1'b0;
        else if (sel_ready && sel_valid && sel_oor)
            sel_err_q <= 1'b1;
    end

    assign sel_err = sel_err_q;

`ifndef SYNTHESIS
    a_sel_in_range: assert property (@(posedge clk) disable iff (reset)
                                     !(sel_ready && sel_valid && sel_oor))
        else $error("merge_n_sync: out-of-range selector");
`endif
`endif

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (chan_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_merge_n_sync.sv
// Directed bench: DUT a (4 inputs, depth 4) and DUT b (3 inputs, depth 2).
module tb_merge_n_sync;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    logic [15:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel;
    logic        a_sel_valid, a_sel_ready;
    logic [3:0]  a_out_data;
    logic        a_out_valid, a_out_ready;
    logic [2:0]  a_count;

    logic [11:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel;
    logic        b_sel_valid, b_sel_ready;
    logic [3:0]  b_out_data;
    logic        b_out_valid, b_out_ready;
    logic [1:0]  b_count;
`ifdef MERGE_SEL_CHECK_EN
    logic        a_sel_err, b_sel_err;
`endif

    merge_n_sync #(.WIDTH(4), .NUM_IN(4), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .count(a_count)
`ifdef MERGE_SEL_CHECK_EN
        , .sel_err(a_sel_err)
`endif
    );

    merge_n_sync #(.WIDTH(4), .NUM_IN(3), .DEPTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .count(b_count)
`ifdef MERGE_SEL_CHECK_EN
        , .sel_err(b_sel_err)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Channel ch carries d, every other channel carries 0xE.
    function automatic logic [15:0] pack_a(input int ch, input logic [3:0] d);
        logic [15:0] v;
        v = 16'hEEEE;
        v[ch*4 +: 4] = d;
        return v;
    endfunction

    function automatic logic [11:0] pack_b(input int ch, input logic [3:0] d);
        logic [11:0] v;
        v = 12'hEEE;
        v[ch*4 +: 4] = d;
        return v;
    endfunction

    task automatic push_a(input int ch, input logic [3:0] d);
        a_sel = 2'(ch); a_sel_valid = 1'b1; tick();
        a_sel_valid = 1'b0; a_in_valid = 4'(1 << ch); a_in_data = pack_a(ch, d); tick();
        a_in_valid = '0;
    endtask

    task automatic push_b(input int ch, input logic [3:0] d);
        b_sel = 2'(ch); b_sel_valid = 1'b1; tick();
        b_sel_valid = 1'b0; b_in_valid = 3'(1 << ch); b_in_data = pack_b(ch, d); tick();
        b_in_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_sel_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_sel_valid = 1'b0; b_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", a_count); end
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        nvec++; if (a_sel_ready !== 1'b1) begin nerr++; $display("FAIL reset_sel_ready: got %b want 1", a_sel_ready); end
        nvec++; if (a_in_ready !== 4'b0000) begin nerr++; $display("FAIL reset_in_ready: got %b want 0000", a_in_ready); end
        nvec++; if (a_out_data !== 4'h0) begin nerr++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
        nvec++; if (b_count !== 2'd0) begin nerr++; $display("FAIL reset_b_count: got %0d want 0", b_count); end
`ifdef MERGE_SEL_CHECK_EN
        nvec++; if (b_sel_err !== 1'b0) begin nerr++; $display("FAIL reset_sel_err: got %b want 0", b_sel_err); end
`endif
    endtask

    task automatic test_single();
        a_sel = 2'd2; a_sel_valid = 1'b1; tick();
        nvec++; if (a_sel_ready !== 1'b0) begin nerr++; $display("FAIL single_sel_ready: got %b want 0", a_sel_ready); end
        nvec++; if (a_in_ready !== 4'b0100) begin nerr++; $display("FAIL single_in_ready: got %b want 0100", a_in_ready); end
        a_sel_valid = 1'b0; a_in_valid = 4'b0100; a_in_data = pack_a(2, 4'hA); a_out_ready = 1'b1;
        #1;
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL single_no_writethrough: got %b want 0", a_out_valid); end
        tick();
        nvec++; if (a_out_valid !== 1'b1) begin nerr++; $display("FAIL single_out_valid: got %b want 1", a_out_valid); end
        nvec++; if (a_out_data !== 4'hA) begin nerr++; $display("FAIL single_out_data: got %h want a", a_out_data); end
        nvec++; if (a_count !== 3'd1) begin nerr++; $display("FAIL single_count: got %0d want 1", a_count); end
        nvec++; if (a_sel_ready !== 1'b1) begin nerr++; $display("FAIL single_back_to_sel: got %b want 1", a_sel_ready); end
        a_in_valid = '0; tick();
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL single_drained: got %0d want 0", a_count); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_order();
        int         chs [3] = '{3, 0, 1};
        logic [3:0] dat [3] = '{4'h3, 4'h0, 4'h1};
        for (int k = 0; k < 3; k++) push_a(chs[k], dat[k]);
        nvec++; if (a_count !== 3'd3) begin nerr++; $display("FAIL order_count: got %0d want 3", a_count); end
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nvec++; if (a_out_data !== dat[k] || a_out_valid !== 1'b1)
                begin nerr++; $display("FAIL order_pkt%0d: got %h/%b want %h/1", k, a_out_data, a_out_valid, dat[k]); end
            tick();
        end
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL order_drained: got %0d want 0", a_count); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_unselected();
        a_sel = 2'd0; a_sel_valid = 1'b1; tick();
        a_sel_valid = 1'b0; a_in_valid = 4'b0010; a_in_data = 16'hEE95;
        for (int k = 0; k < 3; k++) begin
            nvec++; if (a_in_ready !== 4'b0001) begin nerr++; $display("FAIL unsel_in_ready%0d: got %b want 0001", k, a_in_ready); end
            tick();
        end
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL unsel_count: got %0d want 0", a_count); end
        a_in_valid = 4'b0011; tick();
        a_in_valid = '0;
        nvec++; if (a_out_data !== 4'h5) begin nerr++; $display("FAIL unsel_out_data: got %h want 5", a_out_data); end
        nvec++; if (a_count !== 3'd1) begin nerr++; $display("FAIL unsel_count_after: got %0d want 1", a_count); end
        a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
    endtask

    task automatic test_full();
        push_b(0, 4'h1);
        push_b(1, 4'h2);
        nvec++; if (b_count !== 2'd2) begin nerr++; $display("FAIL full_count: got %0d want 2", b_count); end
        b_sel = 2'd2; b_sel_valid = 1'b1; tick();
        b_sel_valid = 1'b0; b_in_valid = 3'b100; b_in_data = pack_b(2, 4'h7);
        for (int k = 0; k < 2; k++) begin
            nvec++; if (b_in_ready !== 3'b000 || b_sel_ready !== 1'b0 || b_count !== 2'd2)
                begin nerr++; $display("FAIL full_hold%0d: got rdy=%b sel_rdy=%b cnt=%0d want 000/0/2", k, b_in_ready, b_sel_ready, b_count); end
            tick();
        end
        b_out_ready = 1'b1;
        nvec++; if (b_out_data !== 4'h1) begin nerr++; $display("FAIL full_head: got %h want 1", b_out_data); end
        tick();
        b_out_ready = 1'b0;
        nvec++; if (b_count !== 2'd1) begin nerr++; $display("FAIL full_no_bypass: got %0d want 1", b_count); end
        nvec++; if (b_in_ready !== 3'b100) begin nerr++; $display("FAIL full_resume_rdy: got %b want 100", b_in_ready); end
        tick();
        b_in_valid = '0;
        nvec++; if (b_count !== 2'd2 || b_sel_ready !== 1'b1)
            begin nerr++; $display("FAIL full_resumed: got cnt=%0d sel_rdy=%b want 2/1", b_count, b_sel_ready); end
        b_out_ready = 1'b1;
        nvec++; if (b_out_data !== 4'h2) begin nerr++; $display("FAIL full_drain0: got %h want 2", b_out_data); end
        tick();
        nvec++; if (b_out_data !== 4'h7) begin nerr++; $display("FAIL full_drain1: got %h want 7", b_out_data); end
        tick();
        nvec++; if (b_count !== 2'd0) begin nerr++; $display("FAIL full_drained: got %0d want 0", b_count); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_bad_sel();
        b_sel = 2'd3; b_sel_valid = 1'b1; tick();
        b_sel_valid = 1'b0;
        nvec++; if (b_sel_ready !== 1'b1 || b_in_ready !== 3'b000)
            begin nerr++; $display("FAIL badsel_state: got sel_rdy=%b rdy=%b want 1/000", b_sel_ready, b_in_ready); end
        nvec++; if (b_count !== 2'd0 || b_out_valid !== 1'b0)
            begin nerr++; $display("FAIL badsel_count: got %0d/%b want 0/0", b_count, b_out_valid); end
`ifdef MERGE_SEL_CHECK_EN
        nvec++; if (b_sel_err !== 1'b1) begin nerr++; $display("FAIL badsel_err: got %b want 1", b_sel_err); end
`endif
        b_sel = 2'd1; b_sel_valid = 1'b1; tick();
        b_sel_valid = 1'b0; b_in_valid = 3'b010; b_in_data = pack_b(1, 4'h4);
        nvec++; if (b_in_ready !== 3'b010) begin nerr++; $display("FAIL badsel_next_rdy: got %b want 010", b_in_ready); end
        tick();
        b_in_valid = '0;
        nvec++; if (b_out_data !== 4'h4 || b_count !== 2'd1)
            begin nerr++; $display("FAIL badsel_next_pkt: got %h/%0d want 4/1", b_out_data, b_count); end
`ifdef MERGE_SEL_CHECK_EN
        nvec++; if (b_sel_err !== 1'b1) begin nerr++; $display("FAIL badsel_err_held: got %b want 1", b_sel_err); end
`endif
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_a(1, 4'h6);
        push_a(3, 4'hC);
        a_sel = 2'd2; a_sel_valid = 1'b1; tick();
        a_sel_valid = 1'b0; a_in_valid = 4'b0100; a_in_data = pack_a(2, 4'h8);
        nvec++; if (a_count !== 3'd2 || a_in_ready !== 4'b0100)
            begin nerr++; $display("FAIL rmid_pre: got cnt=%0d rdy=%b want 2/0100", a_count, a_in_ready); end
        reset = 1'b1; tick(); reset = 1'b0;
        nvec++; if (a_count !== 3'd0 || a_out_valid !== 1'b0)
            begin nerr++; $display("FAIL rmid_fifo: got cnt=%0d vld=%b want 0/0", a_count, a_out_valid); end
        nvec++; if (a_sel_ready !== 1'b1 || a_in_ready !== 4'b0000)
            begin nerr++; $display("FAIL rmid_fsm: got sel_rdy=%b rdy=%b want 1/0000", a_sel_ready, a_in_ready); end
        nvec++; if (a_out_data !== 4'h0) begin nerr++; $display("FAIL rmid_out_data: got %h want 0", a_out_data); end
`ifdef MERGE_SEL_CHECK_EN
        nvec++; if (b_sel_err !== 1'b0) begin nerr++; $display("FAIL rmid_sel_err: got %b want 0", b_sel_err); end
`endif
        a_in_valid = '0; tick();
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL rmid_no_partial: got %0d want 0", a_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_unselected();
        test_full();
        test_bad_sel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/merge_n_sync.md
Name: merge_n_sync

Overview:
- Clocked, parametrised N-input controlled merge, the successor to the 2-input CSP merge.
- A selector token on a select channel chooses which of NUM_IN input channels supplies the next packet.
- Accepted packets are buffered in a DEPTH-entry output FIFO, then driven on a valid/ready output channel.
- Sits in the control datapath wherever several producers share one consumer under explicit ordering.

Parameters:
- WIDTH, 4, packet width in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- DEPTH, 4, output FIFO entries; legal range 1..64, any integer.
- SELW, $clog2(NUM_IN), selector width; derived, not overridden.
- CNTW, $clog2(DEPTH+1), occupancy counter width; derived.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; channel i is bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready.
- sel  in  SELW  selector token.
- sel_valid  in  1  selector valid.
- sel_ready  out  1  selector ready.
- out_data  out  WIDTH  FIFO head packet.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer ready.
- count  out  CNTW  FIFO occupancy.
- sel_err  out  1  sticky selector error; present only with MERGE_SEL_CHECK_EN.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where valid && ready on that channel. Valid must not depend combinationally on ready.
- Reset, sampled at clk edge while reset=1:
  - FSM goes to S_SEL; sel_q=0; FIFO pointers=0; count=0.
  - Outputs: out_valid=0, in_ready=0, sel_ready=1 in the first cycle after reset, out_data=0 (storage is not cleared, only the head mux output is forced to 0 while empty).
  - Reset mid-transfer discards the captured selector and all buffered packets; no partial packet survives.
- FSM, two states:
  - S_SEL: sel_ready=1, in_ready=all 0. On sel transfer: latch sel_q <= sel, go to S_DATA.
  - S_DATA: sel_ready=0. in_ready[sel_q] = (count != DEPTH); all other in_ready bits are 0. On in_valid[sel_q] && in_ready[sel_q]: push the packet and go to S_SEL.
  - Out-of-range selector (sel >= NUM_IN, only possible when NUM_IN is not a power of two): the token is consumed in S_SEL and the FSM stays in S_SEL. No data is transferred.
- Throughput and latency:
  - Peak rate is 1 packet per 2 cycles.
  - A packet pushed at edge t appears with out_valid=1 after edge t (FIFO write-through is not allowed).
- FIFO:
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - Pop on out_valid && out_ready.
  - Pointers wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
  - Full condition: in_ready[sel_q] is deasserted; push is blocked even if a pop occurs in the same cycle (no pop-bypass).
  - Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
  - Pop when empty and push when full are impossible by construction; assertions flag them in simulation.
- Ordering: packets leave in exactly the order their selectors were accepted.

Optional Feature:
- Macro: MERGE_SEL_CHECK_EN.
- Defined:
  - Port sel_err exists, reset to 0.
  - An out-of-range selector transfer sets sel_err=1 on that edge; it stays set until reset.
  - A $error is also issued in simulation.
- Undefined:
  - No sel_err port.
  - Out-of-range selectors are silently consumed and dropped as described above.

Decomposition:
- Package merge_pkg holds:
  - typedef enum logic {S_SEL, S_DATA} merge_state_t;
  - localparam MAX_NUM_IN=16 and MAX_DEPTH=64, used for elaboration-time range checks.
- One sub-module: sync_fifo #(WIDTH, DEPTH).
  - Ports: clk, reset, push, push_data, pop, head_data, count, full, empty.
  - Instantiated once.
  - The FSM and the input mux stay in merge_n_sync.

Test Plan:
- Reset, then sel=2 at cycle 1, in_valid[2]=1 with in_data chan2=0xA at cycle 2, out_ready=1 -> out_valid=1 with out_data=0xA at cycle 3; count returns to 0 at cycle 4.
- Selectors 3,0,1 with data 0x3,0x0,0x1 all valid, out_ready=0 -> count reaches 3; releasing out_ready outputs 0x3,0x0,0x1 in that order.
- DEPTH=2, out_ready=0: four selectors with data -> after 2 pushes in_ready[sel_q]=0 and FSM holds S_DATA. out_ready=1 for one cycle -> push resumes the next cycle.
- Non-selected channel: in_valid[1]=1 while sel_q=0 -> in_ready[1] stays 0 and chan1 data never appears on out_data.
- NUM_IN=3, sel=3 with MERGE_SEL_CHECK_EN -> token consumed, count unchanged, sel_err=1 and held. Without the macro: identical except no sel_err port.
- Reset asserted in S_DATA with count=2 -> the next cycle has count=0, out_valid=0, sel_ready=1, in_ready=0.
